// File: rtl/eth_tx_framer_pkg.sv
// Shared Ethernet framing constants and the TX framer state encoding.
// Also intended for the RX checker (residue compare).
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } eth_state_e;

endpackage

// File: rtl/eth_tx_framer_if.sv
// Control, TX-buffer read port and octet stream of the TX framer.
// The master side is the framer; the slave side is buffer/sink/controller.
interface eth_tx_framer_if;

  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    input  start, len, rd_data, tx_ready,
    output busy, done, err, rd_addr, tx_data, tx_valid
  );

  modport slave (
    output start, len, rd_data, tx_ready,
    input  busy, done, err, rd_addr, tx_data, tx_valid
  );

endinterface

// File: rtl/eth_tx_framer_crc.sv
// Combinational byte-wise CRC-32 update (reflected, bit 0 first).
// Shared between the TX framer and the RX FCS checker.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, buffered payload, zero pad, FCS, IFG.
// Payload is prefetched into a 2-entry byte buffer to hide the read latency.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MTU         = 1536,
  parameter int MIN_PAYLOAD = 60,
  parameter int PAD_EN      = 1,
  parameter int IFG_CYCLES  = 12
) (
  input logic            clk,
  input logic            rst,
  eth_tx_framer_if.master bus
);

  localparam logic [15:0] MTU_W    = 16'(MTU);
  localparam logic [15:0] MIN_W    = 16'(MIN_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 2);
  localparam logic        PAD_ON   = (PAD_EN != 0);
  localparam eth_state_e  ST_POST  = (IFG_CYCLES > 1) ? ST_IFG : ST_IDLE;

  eth_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [15:0] fetch_q, fetch_d;
  logic        infl_q, infl_d;
  logic [1:0]  occ_q, occ_d;
  logic [7:0]  head_q, head_d;
  logic [7:0]  tail_q, tail_d;

  logic        tx_v, hs, pop, issue, fetching;
  logic [7:0]  tx_byte;
  logic [1:0]  pend;
  logic [31:0] crc_nxt, fcs_w;

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (tx_byte),
    .crc_o  (crc_nxt)
  );

  always_comb begin
    tx_v    = 1'b0;
    tx_byte = 8'h00;
    fcs_w   = ~crc_q;
    case (state_q)
      ST_PRE:  begin tx_v = 1'b1; tx_byte = ETH_PREAMBLE; end
      ST_SFD:  begin tx_v = 1'b1; tx_byte = ETH_SFD;      end
      ST_DATA: begin tx_v = 1'b1; tx_byte = head_q;       end
      ST_PAD:  begin tx_v = 1'b1; tx_byte = 8'h00;        end
      ST_FCS: begin
        tx_v = 1'b1;
        case (cnt_q[1:0])
          2'd0:    tx_byte = fcs_w[7:0];
          2'd1:    tx_byte = fcs_w[15:8];
          2'd2:    tx_byte = fcs_w[23:16];
          default: tx_byte = fcs_w[31:24];
        endcase
      end
      default: ;
    endcase
  end

  assign hs           = tx_v && bus.tx_ready;
  assign pop          = (state_q == ST_DATA) && hs;
  assign bus.tx_valid = tx_v;
  assign bus.tx_data  = tx_byte;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rd_addr  = rd_addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    crc_d   = crc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        if (bus.len == 16'd0 || bus.len > MTU_W) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_PRE;
          len_d   = bus.len;
          cnt_d   = 16'd0;
          crc_d   = ETH_CRC_INIT;
        end
      end
      ST_PRE: if (hs) begin
        if (cnt_q == 16'd6) begin
          state_d = ST_SFD;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SFD: if (hs) begin
        state_d = ST_DATA;
        cnt_d   = 16'd0;
      end
      ST_DATA: if (hs) begin
        crc_d = crc_nxt;
        if (cnt_q == len_q - 16'd1) begin
          // cnt keeps running into PAD so it reflects data+pad bytes sent
          if (PAD_ON && len_q < MIN_W) begin
            state_d = ST_PAD;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            state_d = ST_FCS;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_PAD: if (hs) begin
        crc_d = crc_nxt;
        if (cnt_q >= MIN_W - 16'd1) begin
          state_d = ST_FCS;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_FCS: if (hs) begin
        if (cnt_q == 16'd3) begin
          state_d = ST_POST;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IFG: begin
        if (cnt_q >= IFG_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    fetch_d   = fetch_q;
    infl_d    = infl_q;
    occ_d     = occ_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fetching  = (state_q == ST_PRE) || (state_q == ST_SFD) || (state_q == ST_DATA);
    pend      = occ_q + {1'b0, infl_q};
    // a read may issue only if its data will find a free slot on return
    issue     = fetching && (fetch_q < len_q) && ((pend < 2'd2) || pop);
    if (state_q == ST_IDLE) begin
      rd_addr_d = 16'd0;
      fetch_d   = 16'd0;
      infl_d    = 1'b0;
      occ_d     = 2'd0;
    end else begin
      infl_d = issue;
      if (issue) begin
        fetch_d = fetch_q + 16'd1;
        if (fetch_q + 16'd1 < len_q) rd_addr_d = rd_addr_q + 16'd1;
      end
      case ({infl_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_d = bus.rd_data;
          else               tail_d = bus.rd_data;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = bus.rd_data;
          end else begin
            head_d = tail_q;
            tail_d = bus.rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      len_q     <= 16'd0;
      crc_q     <= ETH_CRC_INIT;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_addr_q <= 16'd0;
      fetch_q   <= 16'd0;
      infl_q    <= 1'b0;
      occ_q     <= 2'd0;
      head_q    <= 8'h00;
      tail_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_addr_q <= rd_addr_d;
      fetch_q   <= fetch_d;
      infl_q    <= infl_d;
      occ_q     <= occ_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: an unpadded instance for the CRC check
// vector and a padded instance for pad, stall, error, back-to-back and reset cases.
module tb_eth_tx_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_tx_framer_if bus0 ();
  eth_tx_framer_if bus1 ();

  eth_tx_framer #(.PAD_EN(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  eth_tx_framer #(.PAD_EN(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0] mem [0:2047];
  logic       rnd_mode = 1'b0;
  logic       rnd_bit  = 1'b1;

  always @(posedge clk) begin
    bus0.rd_data <= mem[bus0.rd_addr[10:0]];
    bus1.rd_data <= mem[bus1.rd_addr[10:0]];
    rnd_bit      <= 1'($urandom_range(0, 1));
  end

  assign bus0.tx_ready = 1'b1;
  assign bus1.tx_ready = rnd_mode ? rnd_bit : 1'b1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // ---------------- monitors ----------------
  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  int done_cnt0 = 0;
  int done_cnt1 = 0, err_cnt1 = 0;
  int drop_viol = 0, stab_viol = 0, addr_viol = 0;
  int cur_len1 = 1;
  logic in_frame1 = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.tx_valid && bus0.tx_ready) cap0.push_back(bus0.tx_data);
      if (bus0.done) done_cnt0++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      in_frame1 = 1'b0;
      prev_v    = 1'b0;
    end else begin
      if (bus1.tx_valid && bus1.tx_ready) cap1.push_back(bus1.tx_data);
      if (in_frame1 && !bus1.tx_valid && !bus1.done) drop_viol++;
      if (prev_v && !prev_r && (!bus1.tx_valid || bus1.tx_data !== prev_d)) stab_viol++;
      if (bus1.busy && int'(bus1.rd_addr) >= cur_len1) addr_viol++;
      if (bus1.rd_addr > 16'd1535) addr_viol++;
      if (bus1.done) done_cnt1++;
      if (bus1.err) err_cnt1++;
      in_frame1 = bus1.tx_valid ? 1'b1 : (bus1.done ? 1'b0 : in_frame1);
      prev_v    = bus1.tx_valid;
      prev_r    = bus1.tx_ready;
      prev_d    = bus1.tx_data;
    end
  end

  // ---------------- reference frames ----------------
  logic [7:0] exp1 [$];

  task automatic add_frame(input int len, input bit pad);
    logic [31:0] c;
    int tot;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp1.push_back(8'h55);
    exp1.push_back(8'hD5);
    for (int i = 0; i < len; i++) begin
      exp1.push_back(mem[i]);
      c = crc_upd(c, mem[i]);
    end
    tot = (pad && len < 60) ? 60 : len;
    for (int i = len; i < tot; i++) begin
      exp1.push_back(8'h00);
      c = crc_upd(c, 8'h00);
    end
    c = ~c;
    exp1.push_back(c[7:0]);
    exp1.push_back(c[15:8]);
    exp1.push_back(c[23:16]);
    exp1.push_back(c[31:24]);
  endtask

  task automatic cmp_stream(input string tag, input int base, input int eb);
    int n, mm;
    n  = exp1.size() - eb;
    mm = 0;
    check({tag, "_count"}, 32'(cap1.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i >= cap1.size()) mm++;
      else if (cap1[base + i] !== exp1[eb + i]) mm++;
    end
    check({tag, "_bytes"}, 32'(mm), 32'd0);
  endtask

  task automatic wait_done1(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.done && n < limit);
    check(tag, 32'(bus1.done), 32'd1);
  endtask

  task automatic wait_idle1(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus1.busy && n < limit);
    check(tag, 32'(bus1.busy), 32'd0);
  endtask

  task automatic pulse_start1(input logic [15:0] len);
    @(posedge clk); #1;
    bus1.len   = len;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] exp_a [21];
    logic [31:0] c;
    int base, eb, n, gap, d0, e0, v0, s0, a0;

    exp_a = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
              8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
    bus0.start = 1'b0; bus0.len = 16'd0;
    bus1.start = 1'b0; bus1.len = 16'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",     32'(bus1.busy),     32'd0);
    check("rst_done",     32'(bus1.done),     32'd0);
    check("rst_err",      32'(bus1.err),      32'd0);
    check("rst_tx_valid", 32'(bus1.tx_valid), 32'd0);
    check("rst_tx_data",  32'(bus1.tx_data),  32'd0);
    check("rst_rd_addr",  32'(bus1.rd_addr),  32'd0);

    // A: unpadded "123456789" -> CRC 0xCBF43926
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    @(posedge clk); #1;
    bus0.len = 16'd9; bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus0.done && n < 200);
    check("a_done", 32'(bus0.done), 32'd1);
    repeat (20) @(negedge clk);
    check("a_count", 32'(cap0.size()), 32'd21);
    n = 0;
    for (int i = 0; i < 21; i++) if (i >= cap0.size() || cap0[i] !== exp_a[i]) n++;
    check("a_bytes", 32'(n), 32'd0);
    check("a_done_once", 32'(done_cnt0), 32'd1);

    // B: single byte padded to 60, plus start->first byte latency
    mem[0] = 8'hAB;
    cur_len1 = 1;
    base = cap1.size(); eb = exp1.size();
    add_frame(1, 1'b1);
    @(posedge clk); #1;
    bus1.len = 16'd1; bus1.start = 1'b1;
    @(negedge clk);
    check("b_valid_at_start", 32'(bus1.tx_valid), 32'd0);
    @(posedge clk); #1;
    bus1.start = 1'b0;
    @(negedge clk);
    check("b_valid_next", 32'(bus1.tx_valid), 32'd1);
    check("b_first_byte", 32'(bus1.tx_data),  32'h55);
    check("b_busy",       32'(bus1.busy),     32'd1);
    wait_done1("b_done", 300);
    wait_idle1("b_idle", 50);
    check("b_total72", 32'(cap1.size() - base), 32'd72);
    check("b_data_byte", 32'(cap1[base + 8]), 32'hAB);
    cmp_stream("b", base, eb);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 72 && base + i < cap1.size(); i++) c = crc_upd(c, cap1[base + i]);
    check("b_residue", c, 32'hDEBB20E3);

    // C: MTU-sized frame with random back-pressure
    for (int i = 0; i < 1536; i++) mem[i] = 8'($urandom_range(0, 255));
    cur_len1 = 1536;
    base = cap1.size(); eb = exp1.size();
    d0 = done_cnt1; v0 = drop_viol; s0 = stab_viol; a0 = addr_viol;
    add_frame(1536, 1'b1);
    rnd_mode = 1'b1;
    pulse_start1(16'd1536);
    wait_done1("c_done", 10000);
    wait_idle1("c_idle", 50);
    rnd_mode = 1'b0;
    cmp_stream("c", base, eb);
    check("c_done_once", 32'(done_cnt1 - d0), 32'd1);
    check("c_valid_drop", 32'(drop_viol - v0), 32'd0);
    check("c_data_hold",  32'(stab_viol - s0), 32'd0);
    check("c_rd_addr",    32'(addr_viol - a0), 32'd0);

    // D: illegal lengths
    base = cap1.size(); e0 = err_cnt1;
    pulse_start1(16'd0);
    @(negedge clk);
    check("d_err_len0",  32'(bus1.err),  32'd1);
    check("d_busy_len0", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    check("d_err_clear", 32'(bus1.err), 32'd0);
    pulse_start1(16'd1537);
    @(negedge clk);
    check("d_err_len1537",  32'(bus1.err),  32'd1);
    check("d_busy_len1537", 32'(bus1.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("d_err_pulses", 32'(err_cnt1 - e0), 32'd2);
    check("d_no_bytes",   32'(cap1.size() - base), 32'd0);

    // E: start held high -> back-to-back frames, 12 idle cycles between
    cur_len1 = 5;
    base = cap1.size(); eb = exp1.size();
    d0 = done_cnt1; e0 = err_cnt1;
    add_frame(5, 1'b1);
    add_frame(5, 1'b1);
    @(posedge clk); #1;
    bus1.len = 16'd5; bus1.start = 1'b1;
    wait_done1("e_done1", 400);
    gap = 0;
    while (!bus1.tx_valid && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    check("e_ifg_gap", 32'(gap), 32'd12);
    wait_done1("e_done2", 400);
    @(posedge clk); #1;
    bus1.start = 1'b0;
    wait_idle1("e_idle", 50);
    cmp_stream("e", base, eb);
    check("e_done_twice", 32'(done_cnt1 - d0), 32'd2);
    check("e_no_err",     32'(err_cnt1 - e0),  32'd0);

    // F: reset in the middle of DATA, then a clean frame
    cur_len1 = 100;
    base = cap1.size();
    pulse_start1(16'd100);
    n = 0;
    while (cap1.size() < base + 40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("f_in_data", 32'(cap1.size() >= base + 40), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("f_rst_valid",   32'(bus1.tx_valid), 32'd0);
    check("f_rst_busy",    32'(bus1.busy),     32'd0);
    check("f_rst_rd_addr", 32'(bus1.rd_addr),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = cap1.size();
    repeat (5) @(negedge clk);
    check("f_no_more_bytes", 32'(cap1.size() - base), 32'd0);
    cur_len1 = 3;
    base = cap1.size(); eb = exp1.size();
    add_frame(3, 1'b1);
    pulse_start1(16'd3);
    wait_done1("f_done", 300);
    wait_idle1("f_idle", 50);
    cmp_stream("f", base, eb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
